// File: rtl/tl_enq_pkg.sv
// Shared constants for the TileLink enqueuer: channel widths, field offsets and a
// clog2 helper. The optional flow path is selected with the TL_ENQ_FLOW_EN macro.
package tl_enq_pkg;

  typedef enum logic [2:0] {
    CH_ACQ = 3'd0,
    CH_REL = 3'd1,
    CH_FIN = 3'd2,
    CH_GNT = 3'd3,
    CH_PRB = 3'd4
  } tl_chan_e;

  localparam int ACQ_W = 114;
  localparam int REL_W = 104;
  localparam int GNT_W = 79;
  localparam int FIN_W = 6;
  localparam int PRB_W = 32;

  localparam int ADDR_BLOCK_W = 26;
  localparam int DATA_W       = 64;

  // Acquire packing, LSB first: data, union, a_type, is_builtin_type, addr_beat,
  // client_xact_id, addr_block, dst, src.
  localparam int ACQ_DATA_LSB       = 0;
  localparam int ACQ_UNION_LSB      = 64;
  localparam int ACQ_A_TYPE_LSB     = 76;
  localparam int ACQ_BUILTIN_BIT    = 79;
  localparam int ACQ_ADDR_BEAT_LSB  = 80;
  localparam int ACQ_XACT_ID_BIT    = 83;
  localparam int ACQ_ADDR_BLOCK_LSB = 84;
  localparam int ACQ_DST_LSB        = 110;
  localparam int ACQ_SRC_LSB        = 112;

  localparam int REL_DATA_LSB = 0;
  localparam int GNT_DATA_LSB = 0;

  localparam int FIN_MGR_XACT_LSB = 0;
  localparam int FIN_MGR_XACT_W   = 2;
  localparam int FIN_DST_LSB      = 2;
  localparam int FIN_SRC_LSB      = 4;

  localparam int PRB_P_TYPE_LSB     = 0;
  localparam int PRB_ADDR_BLOCK_LSB = 2;
  localparam int PRB_DST_LSB        = 28;
  localparam int PRB_SRC_LSB        = 30;

  // A single-entry queue still needs a one-bit pointer, hence the floor of 1.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/tl_enq_queue.sv
// One ready/valid FIFO of DEPTH entries; DEPTH 0 degenerates to wires.
// With TL_ENQ_FLOW_EN defined an empty queue forwards enq straight to deq.
module tl_enq_queue
  import tl_enq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enq_valid,
  output logic             o_enq_ready,
  input  logic [WIDTH-1:0] i_enq_bits,
  output logic             o_deq_valid,
  input  logic             i_deq_ready,
  output logic [WIDTH-1:0] o_deq_bits,
  output logic             o_empty
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused_clk;
      assign w_unused_clk = clk ^ rst_n;
      assign o_deq_valid  = i_enq_valid;
      assign o_deq_bits   = i_enq_bits;
      assign o_enq_ready  = i_deq_ready;
      assign o_empty      = 1'b1;
    end else begin : g_fifo
      localparam int PTR_W = clog2_min1(DEPTH);
      localparam int CNT_W = clog2_min1(DEPTH + 1);
      localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
      localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0] r_wr_ptr;
      logic [PTR_W-1:0] r_rd_ptr;
      logic [CNT_W-1:0] r_count;
      logic [PTR_W-1:0] w_wr_ptr_next;
      logic [PTR_W-1:0] w_rd_ptr_next;
      logic             w_empty;
      logic             w_bypass;
      logic             w_enq_fire;
      logic             w_deq_fire;

      assign w_empty       = (r_count == '0);
      assign o_empty       = w_empty;
      assign o_enq_ready   = (r_count != FULL_CNT);
      assign w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      assign w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

`ifdef TL_ENQ_FLOW_EN
      // A beat that can leave in the same cycle it arrives never touches storage.
      assign w_bypass    = w_empty && i_enq_valid && i_deq_ready;
      assign o_deq_valid = !w_empty || i_enq_valid;
      assign o_deq_bits  = w_empty ? i_enq_bits : r_mem[r_rd_ptr];
`else
      assign w_bypass    = 1'b0;
      assign o_deq_valid = !w_empty;
      assign o_deq_bits  = r_mem[r_rd_ptr];
`endif

      assign w_enq_fire = i_enq_valid && o_enq_ready && !w_bypass;
      assign w_deq_fire = i_deq_ready && !w_empty;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
          if (w_enq_fire) begin
            r_mem[r_wr_ptr] <= i_enq_bits;
            r_wr_ptr        <= w_wr_ptr_next;
          end
          if (w_deq_fire) r_rd_ptr <= w_rd_ptr_next;
          if (w_enq_fire && !w_deq_fire) r_count <= r_count + 1'b1;
          else if (!w_enq_fire && w_deq_fire) r_count <= r_count - 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tl_enqueuer_param.sv
// TileLink enqueuer: an independent FIFO per channel plus a global idle flag.
// Build with TL_ENQ_FLOW_EN to give every non-zero-depth FIFO a same-cycle flow path.
module tl_enqueuer_param #(
  parameter int ACQ_DEPTH = 2,
  parameter int REL_DEPTH = 2,
  parameter int GNT_DEPTH = 2,
  parameter int FIN_DEPTH = 0,
  parameter int PRB_DEPTH = 0,
  parameter int ACQ_W     = tl_enq_pkg::ACQ_W,
  parameter int REL_W     = tl_enq_pkg::REL_W,
  parameter int GNT_W     = tl_enq_pkg::GNT_W,
  parameter int FIN_W     = tl_enq_pkg::FIN_W,
  parameter int PRB_W     = tl_enq_pkg::PRB_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_client_acquire_valid,
  output logic             io_client_acquire_ready,
  input  logic [ACQ_W-1:0] io_client_acquire_bits,
  output logic             io_manager_acquire_valid,
  input  logic             io_manager_acquire_ready,
  output logic [ACQ_W-1:0] io_manager_acquire_bits,
  input  logic             io_client_release_valid,
  output logic             io_client_release_ready,
  input  logic [REL_W-1:0] io_client_release_bits,
  output logic             io_manager_release_valid,
  input  logic             io_manager_release_ready,
  output logic [REL_W-1:0] io_manager_release_bits,
  input  logic             io_client_finish_valid,
  output logic             io_client_finish_ready,
  input  logic [FIN_W-1:0] io_client_finish_bits,
  output logic             io_manager_finish_valid,
  input  logic             io_manager_finish_ready,
  output logic [FIN_W-1:0] io_manager_finish_bits,
  input  logic             io_manager_grant_valid,
  output logic             io_manager_grant_ready,
  input  logic [GNT_W-1:0] io_manager_grant_bits,
  output logic             io_client_grant_valid,
  input  logic             io_client_grant_ready,
  output logic [GNT_W-1:0] io_client_grant_bits,
  input  logic             io_manager_probe_valid,
  output logic             io_manager_probe_ready,
  input  logic [PRB_W-1:0] io_manager_probe_bits,
  output logic             io_client_probe_valid,
  input  logic             io_client_probe_ready,
  output logic [PRB_W-1:0] io_client_probe_bits,
  output logic             io_idle
);

  logic [4:0] w_empty;

  tl_enq_queue #(.DEPTH(ACQ_DEPTH), .WIDTH(ACQ_W)) u_acquire (
    .clk(clk), .rst_n(reset),
    .i_enq_valid(io_client_acquire_valid), .o_enq_ready(io_client_acquire_ready),
    .i_enq_bits(io_client_acquire_bits),
    .o_deq_valid(io_manager_acquire_valid), .i_deq_ready(io_manager_acquire_ready),
    .o_deq_bits(io_manager_acquire_bits), .o_empty(w_empty[0])
  );

  tl_enq_queue #(.DEPTH(REL_DEPTH), .WIDTH(REL_W)) u_release (
    .clk(clk), .rst_n(reset),
    .i_enq_valid(io_client_release_valid), .o_enq_ready(io_client_release_ready),
    .i_enq_bits(io_client_release_bits),
    .o_deq_valid(io_manager_release_valid), .i_deq_ready(io_manager_release_ready),
    .o_deq_bits(io_manager_release_bits), .o_empty(w_empty[1])
  );

  tl_enq_queue #(.DEPTH(FIN_DEPTH), .WIDTH(FIN_W)) u_finish (
    .clk(clk), .rst_n(reset),
    .i_enq_valid(io_client_finish_valid), .o_enq_ready(io_client_finish_ready),
    .i_enq_bits(io_client_finish_bits),
    .o_deq_valid(io_manager_finish_valid), .i_deq_ready(io_manager_finish_ready),
    .o_deq_bits(io_manager_finish_bits), .o_empty(w_empty[2])
  );

  tl_enq_queue #(.DEPTH(GNT_DEPTH), .WIDTH(GNT_W)) u_grant (
    .clk(clk), .rst_n(reset),
    .i_enq_valid(io_manager_grant_valid), .o_enq_ready(io_manager_grant_ready),
    .i_enq_bits(io_manager_grant_bits),
    .o_deq_valid(io_client_grant_valid), .i_deq_ready(io_client_grant_ready),
    .o_deq_bits(io_client_grant_bits), .o_empty(w_empty[3])
  );

  tl_enq_queue #(.DEPTH(PRB_DEPTH), .WIDTH(PRB_W)) u_probe (
    .clk(clk), .rst_n(reset),
    .i_enq_valid(io_manager_probe_valid), .o_enq_ready(io_manager_probe_ready),
    .i_enq_bits(io_manager_probe_bits),
    .o_deq_valid(io_client_probe_valid), .i_deq_ready(io_client_probe_ready),
    .o_deq_bits(io_client_probe_bits), .o_empty(w_empty[4])
  );

  // Derived only from stored counts, so idle never glitches with input traffic.
  assign io_idle = &w_empty;

endmodule

// File: tb/tb_tl_enqueuer_param.sv
// Directed plus random checks of tl_enqueuer_param against a per-channel scoreboard.
// Expected latencies follow TL_ENQ_FLOW_EN when the bench is built with it.
module tb_tl_enqueuer_param;
  import tl_enq_pkg::*;

`ifdef TL_ENQ_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic caValid = 1'b0, caReady, maValid, maReady = 1'b0;
  logic [ACQ_W-1:0] caBits = '0, maBits;
  logic crValid = 1'b0, crReady, mrValid, mrReady = 1'b0;
  logic [REL_W-1:0] crBits = '0, mrBits;
  logic cfValid = 1'b0, cfReady, mfValid, mfReady = 1'b0;
  logic [FIN_W-1:0] cfBits = '0, mfBits;
  logic mgValid = 1'b0, mgReady, cgValid, cgReady = 1'b0;
  logic [GNT_W-1:0] mgBits = '0, cgBits;
  logic mpValid = 1'b0, mpReady, cpValid, cpReady = 1'b0;
  logic [PRB_W-1:0] mpBits = '0, cpBits;
  logic ioIdle;

  int total = 0;
  int bad = 0;

  typedef struct {
    int ch;
    logic [127:0] bits;
  } sbEntry_t;
  sbEntry_t sbq[$];

  logic [4:0] monEnqFire, monDeqValid, monDeqReady;
  logic [127:0] monEnqData [5];
  logic [127:0] monDeqData [5];
  logic prevStall [5];
  logic [127:0] prevBits [5];

  tl_enqueuer_param #(
    .ACQ_DEPTH(2), .REL_DEPTH(2), .GNT_DEPTH(3), .FIN_DEPTH(0), .PRB_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .io_client_acquire_valid(caValid), .io_client_acquire_ready(caReady),
    .io_client_acquire_bits(caBits),
    .io_manager_acquire_valid(maValid), .io_manager_acquire_ready(maReady),
    .io_manager_acquire_bits(maBits),
    .io_client_release_valid(crValid), .io_client_release_ready(crReady),
    .io_client_release_bits(crBits),
    .io_manager_release_valid(mrValid), .io_manager_release_ready(mrReady),
    .io_manager_release_bits(mrBits),
    .io_client_finish_valid(cfValid), .io_client_finish_ready(cfReady),
    .io_client_finish_bits(cfBits),
    .io_manager_finish_valid(mfValid), .io_manager_finish_ready(mfReady),
    .io_manager_finish_bits(mfBits),
    .io_manager_grant_valid(mgValid), .io_manager_grant_ready(mgReady),
    .io_manager_grant_bits(mgBits),
    .io_client_grant_valid(cgValid), .io_client_grant_ready(cgReady),
    .io_client_grant_bits(cgBits),
    .io_manager_probe_valid(mpValid), .io_manager_probe_ready(mpReady),
    .io_manager_probe_bits(mpBits),
    .io_client_probe_valid(cpValid), .io_client_probe_ready(cpReady),
    .io_client_probe_bits(cpBits),
    .io_idle(ioIdle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic scoreDeq(input int ch, input logic [127:0] bits);
    int idx;
    idx = -1;
    foreach (sbq[i]) begin
      if (idx < 0 && sbq[i].ch == ch) idx = i;
    end
    checkOutput($sformatf("ch%0d beat expected", ch), 128'(idx >= 0), 128'(1));
    if (idx >= 0) begin
      checkOutput($sformatf("ch%0d order", ch), bits, sbq[idx].bits);
      sbq.delete(idx);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ACQ_W-1:0] mkAcq(input int blk);
    logic [ACQ_W-1:0] v;
    v = '0;
    v[ACQ_ADDR_BLOCK_LSB +: ADDR_BLOCK_W] = ADDR_BLOCK_W'(blk);
    return v;
  endfunction

  function automatic logic [REL_W-1:0] mkRel(input int d);
    logic [REL_W-1:0] v;
    v = '0;
    v[REL_DATA_LSB +: DATA_W] = DATA_W'(d);
    return v;
  endfunction

  function automatic logic [GNT_W-1:0] mkGnt(input int d);
    logic [GNT_W-1:0] v;
    v = '0;
    v[GNT_DATA_LSB +: DATA_W] = DATA_W'(d);
    return v;
  endfunction

  function automatic logic [FIN_W-1:0] mkFin(input int id);
    logic [FIN_W-1:0] v;
    v = '0;
    v[FIN_MGR_XACT_LSB +: FIN_MGR_XACT_W] = FIN_MGR_XACT_W'(id);
    return v;
  endfunction

  function automatic logic [PRB_W-1:0] mkPrb(input int blk);
    logic [PRB_W-1:0] v;
    v = '0;
    v[PRB_ADDR_BLOCK_LSB +: ADDR_BLOCK_W] = ADDR_BLOCK_W'(blk);
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard: accepted beats are pushed, delivered beats popped per channel,
  // and a stalled output must hold valid and bits into the next cycle.
  always @(negedge clk) begin
    monEnqFire  = {mpValid && mpReady, mgValid && mgReady, cfValid && cfReady,
                   crValid && crReady, caValid && caReady};
    monDeqValid = {cpValid, cgValid, mfValid, mrValid, maValid};
    monDeqReady = {cpReady, cgReady, mfReady, mrReady, maReady};
    monEnqData[0] = 128'(caBits);
    monEnqData[1] = 128'(crBits);
    monEnqData[2] = 128'(cfBits);
    monEnqData[3] = 128'(mgBits);
    monEnqData[4] = 128'(mpBits);
    monDeqData[0] = 128'(maBits);
    monDeqData[1] = 128'(mrBits);
    monDeqData[2] = 128'(mfBits);
    monDeqData[3] = 128'(cgBits);
    monDeqData[4] = 128'(cpBits);
    if (reset) begin
      for (int ch = 0; ch < 5; ch++) begin
        if (monEnqFire[ch]) sbq.push_back('{ch: ch, bits: monEnqData[ch]});
      end
      for (int ch = 0; ch < 5; ch++) begin
        if (prevStall[ch]) begin
          checkOutput($sformatf("ch%0d stall valid", ch), 128'(monDeqValid[ch]), 128'(1));
          checkOutput($sformatf("ch%0d stall bits", ch), monDeqData[ch], prevBits[ch]);
        end
        if (monDeqValid[ch] && monDeqReady[ch]) scoreDeq(ch, monDeqData[ch]);
        prevStall[ch] = monDeqValid[ch] && !monDeqReady[ch];
        prevBits[ch]  = monDeqData[ch];
      end
    end else begin
      for (int ch = 0; ch < 5; ch++) prevStall[ch] = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then random traffic on all channels.
  initial begin : applyStimulus
    logic [127:0] r;
    logic [4:0] fire;
    int gSeq;
    int waitCnt;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst idle", ioIdle, 1'b1);
    checkOutput("rst acq valid", maValid, 1'b0);
    checkOutput("rst acq bits", maBits, '0);
    checkOutput("rst acq ready", caReady, 1'b1);
    checkOutput("rst rel ready", crReady, 1'b1);
    checkOutput("rst gnt ready", mgReady, 1'b1);
    checkOutput("rst prb ready", mpReady, 1'b1);
    checkOutput("rst gnt valid", cgValid, 1'b0);
    checkOutput("rst prb valid", cpValid, 1'b0);
    checkOutput("rst fin passthru", mfValid, cfValid);
    stepClk();
    reset = 1'b1;

    // Acquire: two beats fill the queue, the third stalls until a drain.
    stepClk();
    caValid = 1'b1; caBits = mkAcq(1); maReady = 1'b0;
    @(negedge clk);
    checkOutput("acq ready empty", caReady, 1'b1);
    checkOutput("acq latency", maValid, FLOW);
    stepClk();
    caBits = mkAcq(2);
    @(negedge clk);
    checkOutput("acq ready one", caReady, 1'b1);
    checkOutput("acq valid one", maValid, 1'b1);
    checkOutput("acq not idle", ioIdle, 1'b0);
    stepClk();
    caBits = mkAcq(3);
    @(negedge clk);
    checkOutput("acq full ready", caReady, 1'b0);
    stepClk();
    @(negedge clk);
    checkOutput("acq full hold", caReady, 1'b0);
    stepClk();
    maReady = 1'b1;
    @(negedge clk);
    checkOutput("acq head blk1", maBits[ACQ_ADDR_BLOCK_LSB +: ADDR_BLOCK_W], 128'(1));
    checkOutput("acq ready pre deq", caReady, 1'b0);
    stepClk();
    @(negedge clk);
    checkOutput("acq ready post deq", caReady, 1'b1);
    checkOutput("acq head blk2", maBits[ACQ_ADDR_BLOCK_LSB +: ADDR_BLOCK_W], 128'(2));
    stepClk();
    caValid = 1'b0;
    @(negedge clk);
    checkOutput("acq head blk3", maBits[ACQ_ADDR_BLOCK_LSB +: ADDR_BLOCK_W], 128'(3));
    checkOutput("acq valid blk3", maValid, 1'b1);
    stepClk();
    @(negedge clk);
    checkOutput("acq drained", maValid, 1'b0);
    checkOutput("acq idle", ioIdle, 1'b1);

    // Finish has depth 0: outputs follow inputs combinationally.
    stepClk();
    cfValid = 1'b1; cfBits = mkFin(2); mfReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("fin valid", mfValid, 1'b1);
      checkOutput("fin xact", mfBits[FIN_MGR_XACT_LSB +: FIN_MGR_XACT_W], 128'(2));
      checkOutput("fin ready", cfReady, mfReady);
      checkOutput("fin idle", ioIdle, 1'b1);
      stepClk();
      mfReady = ~mfReady;
    end
    cfValid = 1'b0;
    mfReady = 1'b0;

    // Grant depth 3: hold two entries while enqueueing and dequeueing together.
    stepClk();
    gSeq = 1;
    mgValid = 1'b1; mgBits = mkGnt(gSeq); cgReady = 1'b0;
    @(negedge clk);
    checkOutput("gnt fill ready0", mgReady, 1'b1);
    stepClk();
    gSeq++; mgBits = mkGnt(gSeq);
    @(negedge clk);
    checkOutput("gnt fill ready1", mgReady, 1'b1);
    stepClk();
    gSeq++; mgBits = mkGnt(gSeq); cgReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("gnt steady ready", mgReady, 1'b1);
      checkOutput("gnt steady valid", cgValid, 1'b1);
      checkOutput("gnt steady head", cgBits[GNT_DATA_LSB +: DATA_W], 128'(i + 1));
      stepClk();
      if (i == 9) mgValid = 1'b0;
      else begin
        gSeq++;
        mgBits = mkGnt(gSeq);
      end
    end
    @(negedge clk);
    checkOutput("gnt drain a", cgValid, 1'b1);
    stepClk();
    @(negedge clk);
    checkOutput("gnt drain b", cgValid, 1'b1);
    stepClk();
    @(negedge clk);
    checkOutput("gnt drain empty", cgValid, 1'b0);

    // Release: reset with two beats queued discards them.
    stepClk();
    crValid = 1'b1; crBits = mkRel(7); mrReady = 1'b0;
    stepClk();
    crBits = mkRel(8);
    stepClk();
    crValid = 1'b0;
    #1;
    reset = 1'b0;
    sbq.delete();
    #1;
    checkOutput("rel rst valid", mrValid, 1'b0);
    checkOutput("rel rst bits", mrBits, '0);
    checkOutput("rel rst idle", ioIdle, 1'b1);
    checkOutput("rel rst ready", crReady, 1'b1);
    @(negedge clk);
    stepClk();
    reset = 1'b1;
    stepClk();
    crValid = 1'b1; crBits = mkRel(9); mrReady = 1'b1;
    @(negedge clk);
    checkOutput("rel post rst latency", mrValid, FLOW);
    stepClk();
    crValid = 1'b0;
    @(negedge clk);
    checkOutput("rel post rst deliver", mrValid, !FLOW);
    stepClk();
    mrReady = 1'b0;

    // Probe on an empty queue: same-cycle with flow, one cycle later without.
    stepClk();
    mpValid = 1'b1; mpBits = mkPrb(16'h55); cpReady = 1'b1;
    @(negedge clk);
    checkOutput("prb first valid", cpValid, FLOW);
    checkOutput("prb first idle", ioIdle, 1'b1);
    stepClk();
    mpValid = 1'b0;
    @(negedge clk);
    checkOutput("prb second valid", cpValid, !FLOW);
    checkOutput("prb second idle", ioIdle, FLOW);
    stepClk();
    @(negedge clk);
    checkOutput("prb done valid", cpValid, 1'b0);
    checkOutput("prb done idle", ioIdle, 1'b1);

    // Random traffic; sources hold a beat until it transfers, then drain.
    for (int cyc = 0; cyc < 10040; cyc++) begin
      @(negedge clk);
      fire = {mpValid && mpReady, mgValid && mgReady, cfValid && cfReady,
              crValid && crReady, caValid && caReady};
      stepClk();
      if (!caValid || fire[0]) begin
        r = rnd128(); caBits = r[ACQ_W-1:0];
        caValid = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!crValid || fire[1]) begin
        r = rnd128(); crBits = r[REL_W-1:0];
        crValid = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!cfValid || fire[2]) begin
        r = rnd128(); cfBits = r[FIN_W-1:0];
        cfValid = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!mgValid || fire[3]) begin
        r = rnd128(); mgBits = r[GNT_W-1:0];
        mgValid = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!mpValid || fire[4]) begin
        r = rnd128(); mpBits = r[PRB_W-1:0];
        mpValid = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      maReady = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      mrReady = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      mfReady = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      cgReady = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      cpReady = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    waitCnt = 0;
    @(negedge clk);
    while (!ioIdle && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("final idle", ioIdle, 1'b1);
    checkOutput("final scoreboard empty", 128'(sbq.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_enqueuer_param.md
Name: tl_enqueuer_param

Overview:
- Parametrised TileLink enqueuer for the tile-to-uncore boundary. Inserts an independent, configurable-depth FIFO on each of the five TileLink channels: acquire, release and finish (client to manager), grant and probe (manager to client).
- A depth of 0 on a channel makes that channel a combinational pass-through, identical to the current zero-depth enqueuer.
- Adds a global idle indication so the clock-gating and flush logic can tell when nothing is in flight.

Parameters:
- ACQ_DEPTH, 2, acquire FIFO entries (0 = pass-through; max 16).
- REL_DEPTH, 2, release FIFO entries (0 to 16).
- GNT_DEPTH, 2, grant FIFO entries (0 to 16).
- FIN_DEPTH, 0, finish FIFO entries (0 to 16).
- PRB_DEPTH, 0, probe FIFO entries (0 to 16).
- ACQ_W, 114, packed acquire width: header src/dst 2+2, addr_block 26, client_xact_id 1, addr_beat 3, is_builtin_type 1, a_type 3, union 12, data 64.
- REL_W, 104, packed release width: src/dst, addr_beat, addr_block, client_xact_id, voluntary, r_type, data.
- GNT_W, 79, packed grant width: src/dst, addr_beat, client_xact_id, manager_xact_id, is_builtin_type, g_type, data.
- FIN_W, 6, packed finish width: src/dst, manager_xact_id.
- PRB_W, 32, packed probe width: src/dst, addr_block, p_type.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- io_client_acquire_valid / _ready / _bits  in / out / in  1 / 1 / ACQ_W  client acquire.
- io_manager_acquire_valid / _ready / _bits  out / in / out  1 / 1 / ACQ_W  manager acquire.
- io_client_release_valid / _ready / _bits  in / out / in  1 / 1 / REL_W.
- io_manager_release_valid / _ready / _bits  out / in / out  1 / 1 / REL_W.
- io_client_finish_valid / _ready / _bits  in / out / in  1 / 1 / FIN_W.
- io_manager_finish_valid / _ready / _bits  out / in / out  1 / 1 / FIN_W.
- io_manager_grant_valid / _ready / _bits  in / out / in  1 / 1 / GNT_W.
- io_client_grant_valid / _ready / _bits  out / in / out  1 / 1 / GNT_W.
- io_manager_probe_valid / _ready / _bits  in / out / in  1 / 1 / PRB_W.
- io_client_probe_valid / _ready / _bits  out / in / out  1 / 1 / PRB_W.
- io_idle  out  1  high when every FIFO is empty.

Behaviour:
- Each channel is a ready/valid decoupled link. A beat transfers on the rising clk edge where valid && ready.
- Once a source asserts valid, it holds valid and bits stable until the transfer. The block honours this on its own outputs.
- Depth 0 channel:
  - deq_valid = enq_valid, deq_bits = enq_bits, enq_ready = deq_ready; no state.
  - This channel always reads as empty for io_idle.
- Depth N>0 FIFO state:
  - wr_ptr and rd_ptr, each clog2(N) bits (minimum 1), wrap from N-1 to 0. Non-power-of-two N is supported.
  - count, clog2(N+1) bits.
  - Storage is N x W flops.
- FIFO handshake:
  - enq_ready = (count != N).
  - deq_valid = (count != 0); deq_bits = mem[rd_ptr].
  - Registered output: minimum latency 1 cycle from enqueue to deq_valid.
- Simultaneous enqueue and dequeue:
  - Non-full, non-empty: both pointers advance, count unchanged.
  - Full: enq_ready=0, so only the dequeue occurs.
  - Empty: only the enqueue occurs, unless flow mode is compiled in.
- Full: enq_ready drops in the cycle count reaches N, and rises the cycle after a dequeue.
- Empty: deq_valid=0; deq_bits holds its last value and must not be checked.
- Ordering: strict FIFO per channel. No cross-channel ordering is guaranteed.
- io_idle = AND over all channels of (count == 0). It is registered-state only and has no combinational path from inputs.
- Reset (reset low, asynchronous assert, synchronous deassert expected upstream):
  - Pointers, counts and storage go to 0.
  - All deq valids go to 0, all deq bits to 0, all enq readies to 1 for depth>0, and io_idle to 1.
  - Reset mid-transfer discards all queued beats. No transfer completes on the reset edge.

Optional Feature:
- Macro TL_ENQ_FLOW_EN.
- Defined: every depth>0 FIFO gains a flow path.
  - When count==0 and enq_valid, deq_valid=1 and deq_bits=enq_bits in the same cycle.
  - If deq_ready is also high, the beat bypasses storage: pointers and count are unchanged.
  - Latency drops to 0 on an empty queue.
- Undefined: no combinational path from enq to deq. Latency is 1 cycle minimum.

Decomposition:
- Package tl_enq_pkg holds:
  - the channel width constants (ACQ_W, REL_W, GNT_W, FIN_W, PRB_W);
  - the field offset constants for pack/unpack;
  - a clog2-with-min-1 function.
- One sub-module, tl_enq_queue (params DEPTH, WIDTH), instantiated five times. A generate branch handles DEPTH==0 as wires.

Test Plan:
- Defaults; client sends acquire beats with addr_block 0x1, 0x2, 0x3, manager_ready=0 -> first two accepted, third stalls with client_acquire_ready=0. Manager then drains 0x1, 0x2, 0x3 in order; io_idle returns to 1.
- GNT_DEPTH=3; fill 2, then enqueue and dequeue in the same cycle for 10 cycles -> count stays 2, no drops, data order preserved; rd_ptr wraps 2->0.
- FIN_DEPTH=0; finish valid with manager_xact_id=2, manager ready toggling -> outputs track inputs in the same cycle, client_finish_ready equals manager_finish_ready.
- Assert reset low with 2 release beats queued -> valid=0, bits=0 and io_idle=1 immediately. After release of reset, the next beat is the first delivered.
- TL_ENQ_FLOW_EN defined, empty probe FIFO (PRB_DEPTH=2) with client_probe_ready=1 -> beat appears on client_probe same cycle, count stays 0. Undefined -> appears 1 cycle later.
- Random valid/ready on all five channels for 10k cycles against a scoreboard -> no loss, duplication or reordering; valid/bits stable while stalled.
